safety_wdt_mc: RTL

Multi-channel windowed safety watchdog for the safety island, the parametrised successor to the single-channel watchdog. Each of `NUM_CH` channels runs an independent window (open/close) with early-kick and late-kick (timeout) detection, pre-timeout warning and a sticky fault that cannot be escaped by disabling the channel. External safety error inputs merge into one sticky fault. A heartbeat pulse for the external watchdog IC stops while any fault is pending.

---
 rtl/safety_wdt_mc_if.sv | 37 +++
 rtl/safety_wdt_mc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/safety_wdt_mc_if.sv
// Configuration, kick, error and status bundle of the multi-channel safety watchdog.
// master: the system side (drives cfg/kick/errors/clear, observes status)
// slave : the watchdog itself
//   cfg_enable_i[NUM_CH]      per-channel enable
//   cfg_open_i/cfg_close_i    packed window bounds, channel c at [c*CNT_W +: CNT_W]
//   kick_i[NUM_CH]            per-channel single-cycle kick
//   ext_err_i[NUM_ERR]        level error inputs from other safety modules
//   fault_clr_i               clears all sticky faults
//   warn_o, timeout_o, early_o, cfg_err_o [NUM_CH], fault_o, pulse_o
interface safety_wdt_mc_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_ERR = 2
);
  logic [NUM_CH-1:0]       cfg_enable_i;
  logic [NUM_CH*CNT_W-1:0] cfg_open_i;
  logic [NUM_CH*CNT_W-1:0] cfg_close_i;
  logic [NUM_CH-1:0]       kick_i;
  logic [NUM_ERR-1:0]      ext_err_i;
  logic                    fault_clr_i;
  logic [NUM_CH-1:0]       warn_o;
  logic [NUM_CH-1:0]       timeout_o;
  logic [NUM_CH-1:0]       early_o;
  logic [NUM_CH-1:0]       cfg_err_o;
  logic                    fault_o;
  logic                    pulse_o;

  modport master (
    output cfg_enable_i, cfg_open_i, cfg_close_i, kick_i, ext_err_i, fault_clr_i,
    input  warn_o, timeout_o, early_o, cfg_err_o, fault_o, pulse_o
  );

  modport slave (
    input  cfg_enable_i, cfg_open_i, cfg_close_i, kick_i, ext_err_i, fault_clr_i,
    output warn_o, timeout_o, early_o, cfg_err_o, fault_o, pulse_o
  );
endinterface

// File: rtl/safety_wdt_mc.sv
// Multi-channel windowed safety watchdog with sticky faults, external error merge
// and a heartbeat for the external watchdog IC.
// Ports:
//   clk_i  safety clock
//   rst_i  synchronous active-high reset
//   bus    safety_wdt_mc_if.slave: configuration, kicks, errors and status outputs
module safety_wdt_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WARN_MARGIN = 256,
  parameter int unsigned NUM_ERR     = 2,
  parameter int unsigned PULSE_HI    = 100,
  parameter int unsigned PULSE_LO    = 100
) (
  input logic            clk_i,
  input logic            rst_i,
  safety_wdt_mc_if.slave bus
);

  localparam int unsigned HB_W    = $clog2(PULSE_HI + PULSE_LO);
  localparam int unsigned HB_LAST = PULSE_HI + PULSE_LO - 1;

  localparam logic [CNT_W-1:0] MARGIN = CNT_W'(WARN_MARGIN);

  localparam logic [1:0] ST_DIS = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_FLT = 2'd2;

  logic [NUM_CH-1:0][1:0]       st_q, st_n;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_n;
  logic [NUM_CH-1:0][CNT_W-1:0] open_q, open_n;
  logic [NUM_CH-1:0][CNT_W-1:0] close_q, close_n;
  logic [NUM_CH-1:0]            warn_q, warn_n;
  logic [NUM_CH-1:0]            to_q, to_n;
  logic [NUM_CH-1:0]            early_q, early_n;
  logic [NUM_CH-1:0]            cerr_q, cerr_n;
  logic                         ext_flt_q, ext_flt_n;
  logic                         fault_q, fault_n;
  logic                         pulse_q, pulse_n;
  logic [HB_W-1:0]              hb_q, hb_n;

  logic [CNT_W-1:0] cfg_open;
  logic [CNT_W-1:0] cfg_close;
  logic [CNT_W-1:0] thr;
  logic             cfg_bad;
  logic             any_flt;
  logic             ext_any;

  // Next-state and registered-output logic for all channels, errors and heartbeat
  always_comb begin
    st_n      = st_q;
    cnt_n     = cnt_q;
    open_n    = open_q;
    close_n   = close_q;
    to_n      = to_q;
    early_n   = early_q;
    cerr_n    = '0;
    warn_n    = '0;
    cfg_open  = '0;
    cfg_close = '0;
    thr       = '0;
    cfg_bad   = 1'b0;
    any_flt   = 1'b0;

    for (int c = 0; c < NUM_CH; c++) begin
      cfg_open  = bus.cfg_open_i[c*CNT_W +: CNT_W];
      cfg_close = bus.cfg_close_i[c*CNT_W +: CNT_W];
      cfg_bad   = !((cfg_open < cfg_close) && (cfg_close != '0));

      case (st_q[c])
        ST_DIS: begin
          cnt_n[c] = '0;
          if (bus.cfg_enable_i[c]) begin
            open_n[c]  = cfg_open;
            close_n[c] = cfg_close;
            if (!cfg_bad) st_n[c] = ST_RUN;
          end
        end
        ST_RUN: begin
          // Faults take precedence over disable and over a clear in the same cycle
          if (cnt_q[c] >= close_q[c]) begin
            st_n[c] = ST_FLT;
            to_n[c] = 1'b1;
          end else if (bus.kick_i[c] && (cnt_q[c] < open_q[c])) begin
            st_n[c]    = ST_FLT;
            early_n[c] = 1'b1;
          end else if (!bus.cfg_enable_i[c]) begin
            st_n[c]  = ST_DIS;
            cnt_n[c] = '0;
          end else if (bus.kick_i[c]) begin
            cnt_n[c] = '0;
          end else if (!(&cnt_q[c])) begin
            cnt_n[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        ST_FLT: begin
          // Counter freezes; only a clear leaves this state
          if (bus.fault_clr_i) begin
            st_n[c]    = ST_DIS;
            cnt_n[c]   = '0;
            to_n[c]    = 1'b0;
            early_n[c] = 1'b0;
          end
        end
        default: begin
          st_n[c]  = ST_DIS;
          cnt_n[c] = '0;
        end
      endcase

      // Config error holds until enable drops
      cerr_n[c] = bus.cfg_enable_i[c] && (cerr_q[c] || ((st_q[c] == ST_DIS) && cfg_bad));

      // Warn is evaluated on the next-state values so it lines up with the counter
      thr       = (close_n[c] >= MARGIN) ? (close_n[c] - MARGIN) : '0;
      warn_n[c] = (st_n[c] == ST_RUN) && (cnt_n[c] >= thr);
      any_flt   = any_flt || (st_n[c] == ST_FLT);
    end

    // External fault clears only once every source is quiet
    ext_any   = |bus.ext_err_i;
    ext_flt_n = ext_any || (ext_flt_q && !bus.fault_clr_i);
    fault_n   = any_flt || ext_flt_n;

    // Heartbeat counter free-runs; the output is masked by any pending fault
    hb_n    = (hb_q == HB_W'(HB_LAST)) ? '0 : hb_q + HB_W'(1);
    pulse_n = (hb_q < HB_W'(PULSE_HI)) && !fault_n;
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= '0;
      cnt_q     <= '0;
      open_q    <= '0;
      close_q   <= '0;
      warn_q    <= '0;
      to_q      <= '0;
      early_q   <= '0;
      cerr_q    <= '0;
      ext_flt_q <= 1'b0;
      fault_q   <= 1'b0;
      pulse_q   <= 1'b0;
      hb_q      <= '0;
    end else begin
      st_q      <= st_n;
      cnt_q     <= cnt_n;
      open_q    <= open_n;
      close_q   <= close_n;
      warn_q    <= warn_n;
      to_q      <= to_n;
      early_q   <= early_n;
      cerr_q    <= cerr_n;
      ext_flt_q <= ext_flt_n;
      fault_q   <= fault_n;
      pulse_q   <= pulse_n;
      hb_q      <= hb_n;
    end
  end

  assign bus.warn_o    = warn_q;
  assign bus.timeout_o = to_q;
  assign bus.early_o   = early_q;
  assign bus.cfg_err_o = cerr_q;
  assign bus.fault_o   = fault_q;
  assign bus.pulse_o   = pulse_q;

endmodule
